noc_inject_arbiter: RTL

//  Shares one NoC router local injection port among NUM_REQ requesters, e.g. test/compute nodes on one tile.

---
 rtl/noc_inject_arbiter_pkg.sv | 14 +
 rtl/noc_rr_pick.sv | 35 +++
 rtl/noc_inject_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/noc_inject_arbiter_pkg.sv
// Shared types and helpers for the NoC local injection arbiter.
// Holds the FSM state encoding and the round-robin pointer wrap.
package noc_inject_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_e;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/noc_rr_pick.sv
// Round-robin picker: first set bit of req_mask at or after rr_ptr.
// Pure combinational; returns one-hot winner, its index and a found flag.
module noc_rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_mask,
    input  logic [IW-1:0] rr_ptr,
    output logic [N-1:0]  win_oh,
    output logic [IW-1:0] win_idx,
    output logic          win_any
);

    // scan N positions starting at rr_ptr, wrapping, keep the first hit
    always_comb begin
        int s;
        logic [IW-1:0] j;
        win_oh  = '0;
        win_idx = '0;
        win_any = 1'b0;
        s       = 0;
        j       = '0;
        for (int k = 0; k < N; k++) begin
            s = int'(rr_ptr) + k;
            if (s >= N) s = s - N;
            j = IW'(s);
            if (!win_any && req_mask[j]) begin
                win_any    = 1'b1;
                win_idx    = j;
                win_oh[j]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/noc_inject_arbiter.sv
// Wormhole packet-level round-robin arbiter for a router injection port.
// Owner holds the port header-to-tail; output is one registered stage.
module noc_inject_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int FLIT_W      = 32,
    parameter int MAX_PKT_LEN = 16
) (
    input  logic                      noc_clk,
    input  logic                      noc_rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*FLIT_W-1:0] req_flit,
    input  logic [NUM_REQ-1:0]        req_is_header,
    input  logic [NUM_REQ-1:0]        req_is_tail,
    output logic                      sender_valid,
    input  logic                      sender_ready,
    output logic [FLIT_W-1:0]         sender_flit,
    output logic                      sender_is_header,
    output logic                      sender_is_tail,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      busy,
    output logic                      pkt_err
);
    import noc_inject_arbiter_pkg::*;

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_PKT_LEN + 1);

    arb_state_e        state_q;
    arb_state_e        state_d;
    logic [IW-1:0]     owner_q;
    logic [IW-1:0]     rr_ptr_q;
    logic [CW-1:0]     cnt_q;
    logic [CW-1:0]     cnt_inc;
    logic [NUM_REQ-1:0] cand;
    logic [NUM_REQ-1:0] pick_oh;
    logic [IW-1:0]     pick_idx;
    logic              pick_any;
    logic [IW-1:0]     sel_idx;
    logic              out_ready;
    logic              xfer;
    logic [FLIT_W-1:0] sel_flit;
    logic              sel_hdr;
    logic              sel_tail;

    // only headers compete, and only while the port is free
    always_comb begin
        out_ready = !sender_valid || sender_ready;
        cand      = (state_q == ARB_IDLE) ? (req_valid & req_is_header) : '0;
    end

    noc_rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .req_mask (cand),
        .rr_ptr   (rr_ptr_q),
        .win_oh   (pick_oh),
        .win_idx  (pick_idx),
        .win_any  (pick_any)
    );

    // next state, per-requester ready and the selected flit
    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        sel_idx   = owner_q;
        if (state_q == ARB_IDLE) begin
            sel_idx             = pick_idx;
            req_ready[pick_idx] = pick_any && out_ready;
        end else begin
            req_ready[owner_q]  = out_ready;
        end
        xfer     = |(req_valid & req_ready);
        sel_flit = req_flit[int'(sel_idx)*FLIT_W +: FLIT_W];
        sel_hdr  = req_is_header[sel_idx];
        sel_tail = req_is_tail[sel_idx];
        cnt_inc  = (cnt_q == CW'(MAX_PKT_LEN)) ? cnt_q : cnt_q + CW'(1);
        unique case (state_q)
            ARB_IDLE: if (xfer && !sel_tail) state_d = ARB_LOCK;
            ARB_LOCK: if (xfer && sel_tail)  state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    // ownership, fairness pointer, length counter and sticky error
    always_ff @(posedge noc_clk or posedge noc_rst) begin
        if (noc_rst) begin
            state_q  <= ARB_IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            grant    <= '0;
            pkt_err  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (xfer) begin
                unique case (state_q)
                    ARB_IDLE: begin
                        if (sel_tail) begin
                            rr_ptr_q <= IW'(wrap_inc(int'(pick_idx), NUM_REQ));
                        end else begin
                            owner_q <= pick_idx;
                            grant   <= pick_oh;
                            cnt_q   <= CW'(1);
                        end
                    end
                    ARB_LOCK: begin
                        cnt_q <= cnt_inc;
                        if (sel_hdr) pkt_err <= 1'b1;
                        if (cnt_inc == CW'(MAX_PKT_LEN) && !sel_tail)
                            pkt_err <= 1'b1;
                        if (sel_tail) begin
                            grant    <= '0;
                            cnt_q    <= '0;
                            rr_ptr_q <= IW'(wrap_inc(int'(owner_q), NUM_REQ));
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // output pipeline register toward the router
    always_ff @(posedge noc_clk or posedge noc_rst) begin
        if (noc_rst) begin
            sender_valid     <= 1'b0;
            sender_flit      <= '0;
            sender_is_header <= 1'b0;
            sender_is_tail   <= 1'b0;
        end else if (xfer) begin
            sender_valid     <= 1'b1;
            sender_flit      <= sel_flit;
            sender_is_header <= sel_hdr;
            sender_is_tail   <= sel_tail;
        end else if (sender_ready) begin
            sender_valid     <= 1'b0;
        end
    end

    assign busy = (state_q == ARB_LOCK);

endmodule
